// File: rtl/wb_unit_if.sv
// ----------------------------------------------------------------------------
// wb_unit_if -- bundle of every signal between the writeback stage and its
// neighbours (execute, load issue, data memory response, register file write
// port, decode scoreboard).
//
//   ex_valid/ex_ready/ex_rd/ex_result  execute result handshake
//   ld_valid/ld_ready/ld_rd/ld_funct3/ld_off  load issue handshake
//   mem_rvalid/mem_rdata               in-order load response (no backpressure)
//   rf_we/rf_waddr/rf_wdata            registered register-file write
//   busy                               per-register pending-load scoreboard
//   err                                sticky: response with empty queue
//
// slave  : the writeback unit itself
// master : the surrounding pipeline (or a testbench) driving the unit
// ----------------------------------------------------------------------------
interface wb_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;

  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;

  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] busy;
  logic        err;

  modport slave (
    input  ex_valid, ex_rd, ex_result,
    input  ld_valid, ld_rd, ld_funct3, ld_off,
    input  mem_rvalid, mem_rdata,
    output ex_ready, ld_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy, err
  );

  modport master (
    output ex_valid, ex_rd, ex_result,
    output ld_valid, ld_rd, ld_funct3, ld_off,
    output mem_rvalid, mem_rdata,
    input  ex_ready, ld_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy, err
  );
endinterface

// File: rtl/wb_unit.sv
// ----------------------------------------------------------------------------
// wb_unit -- writeback stage feeding the register file write port.
//
// Merges single-cycle execute results with in-order load responses. Issued
// loads are remembered in a small FIFO ({rd, funct3, off}) so that the matching
// response can be formatted (byte/half/word, signed/unsigned). A load response
// always wins the single write port; the execute side is back-pressured via
// ex_ready. A per-register busy scoreboard lets decode stall on pending load
// destinations.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  wb_unit_if.slave (see wb_unit_if.sv for the signal list)
//
// Parameter:
//   LQ_DEPTH  outstanding-load queue depth (power of two, >= 1)
// ----------------------------------------------------------------------------
module wb_unit #(
  parameter int LQ_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  wb_unit_if.slave bus
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } lq_entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  lq_entry_t        lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic             err_q, err_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  lq_entry_t        head;
  lq_entry_t        new_entry;

  // --------------------------------------------------------------------------
  // Load data formatting: pick the addressed byte/half from the aligned word
  // and extend it. funct3[2] distinguishes the unsigned variants.
  // --------------------------------------------------------------------------
  function automatic logic [31:0] format_load(input logic [2:0]  funct3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfwords are selected by off[1] only; a misaligned off[0] is ignored.
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  res = {24'h0, byte_sel};
      3'b001:  res = {{16{half_sel[15]}}, half_sel};
      3'b101:  res = {16'h0, half_sel};
      default: res = word;
    endcase
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  assign full  = (count_q == CNT_W'(LQ_DEPTH));
  assign empty = (count_q == '0);
  assign head  = lq_mem[rd_ptr_q];

  // busy_q[0] is never set, so loads to x0 are accepted whenever not full.
  // A pop this cycle does not free a slot until next cycle.
  assign bus.ld_ready = !full && !busy_q[bus.ld_rd];
  assign bus.ex_ready = !bus.mem_rvalid;

  assign push = bus.ld_valid && bus.ld_ready;
  assign pop  = bus.mem_rvalid && !empty;

  assign new_entry = '{rd: bus.ld_rd, funct3: bus.ld_funct3, off: bus.ld_off};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    err_d      = err_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(LQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(LQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Clear before set: the same rd can never be both (ld_ready blocks it),
    // so the order only matters for readability.
    if (pop) begin
      busy_d[head.rd] = 1'b0;
    end
    if (push && (bus.ld_rd != 5'd0)) begin
      busy_d[bus.ld_rd] = 1'b1;
    end

    if (bus.mem_rvalid && empty) begin
      err_d = 1'b1;
    end

    // Single write port: load response first, then execute result.
    if (pop) begin
      rf_we_d    = (head.rd != 5'd0);
      rf_waddr_d = head.rd;
      rf_wdata_d = format_load(head.funct3, head.off, bus.mem_rdata);
    end else if (bus.ex_valid && !bus.mem_rvalid) begin
      rf_we_d    = (bus.ex_rd != 5'd0);
      rf_waddr_d = bus.ex_rd;
      rf_wdata_d = bus.ex_result;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: queue storage has no reset; an entry is only read after it has been
  // written, and the pointers/count (which are reset) decide that.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem[wr_ptr_q] <= new_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// ----------------------------------------------------------------------------
// tb_wb_unit -- directed self-checking bench for wb_unit (LQ_DEPTH = 2).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (registered values) or 1 ns after driving (combinational handshakes).
// ----------------------------------------------------------------------------
module tb_wb_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  wb_unit_if u_if ();

  wb_unit #(.LQ_DEPTH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decode must never present an execute result to a busy register.
  always @(posedge clk) begin
    if (!rst && u_if.ex_valid && u_if.busy[u_if.ex_rd]) begin
      check("ex_rd_busy_violation", 32'd1, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    u_if.ex_valid   = 1'b0;
    u_if.ex_rd      = '0;
    u_if.ex_result  = '0;
    u_if.ld_valid   = 1'b0;
    u_if.ld_rd      = '0;
    u_if.ld_funct3  = '0;
    u_if.ld_off     = '0;
    u_if.mem_rvalid = 1'b0;
    u_if.mem_rdata  = '0;
  endtask

  // Issue one load, respond one cycle later, check busy and the formatted write.
  task automatic load_fmt(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] rdata,
                          input logic [31:0] exp);
    @(negedge clk);
    u_if.ld_valid  = 1'b1;
    u_if.ld_rd     = rd;
    u_if.ld_funct3 = f3;
    u_if.ld_off    = off;
    #1 check({tag, "_ld_ready"}, u_if.ld_ready, 32'd1);
    @(negedge clk);
    u_if.ld_valid = 1'b0;
    check({tag, "_busy_set"}, u_if.busy, 32'd1 << rd);
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = rdata;
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check({tag, "_we"},    u_if.rf_we,    32'd1);
    check({tag, "_waddr"}, u_if.rf_waddr, 32'(rd));
    check({tag, "_wdata"}, u_if.rf_wdata, exp);
    check({tag, "_busy_clr"}, u_if.busy, 32'd0);
  endtask

  task automatic respond(input logic [31:0] rdata);
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = rdata;
  endtask

  initial begin
    idle_inputs();

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_rf_we",    u_if.rf_we,    32'd0);
    check("rst_rf_waddr", u_if.rf_waddr, 32'd0);
    check("rst_rf_wdata", u_if.rf_wdata, 32'd0);
    check("rst_busy",     u_if.busy,     32'd0);
    check("rst_err",      u_if.err,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ld_ready", u_if.ld_ready, 32'd1);
    check("rst_ex_ready", u_if.ex_ready, 32'd1);

    // ---------------- execute write ----------------
    u_if.ex_valid  = 1'b1;
    u_if.ex_rd     = 5'd5;
    u_if.ex_result = 32'h1234_5678;
    @(negedge clk);
    check("ex_we",    u_if.rf_we,    32'd1);
    check("ex_waddr", u_if.rf_waddr, 32'd5);
    check("ex_wdata", u_if.rf_wdata, 32'h1234_5678);
    u_if.ex_rd     = 5'd0;
    u_if.ex_result = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ex_x0_we", u_if.rf_we, 32'd0);
    u_if.ex_valid = 1'b0;
    @(negedge clk);
    check("idle_we", u_if.rf_we, 32'd0);

    // ---------------- load formatting ----------------
    load_fmt("lb_off3",  5'd7,  3'b000, 2'd3, 32'h80FF_FF01, 32'hFFFF_FF80);
    load_fmt("lbu_off3", 5'd7,  3'b100, 2'd3, 32'h80FF_FF01, 32'h0000_0080);
    load_fmt("lhu_off2", 5'd7,  3'b101, 2'd2, 32'h80FF_FF01, 32'h0000_80FF);
    load_fmt("lh_off0",  5'd7,  3'b001, 2'd0, 32'h80FF_FF01, 32'hFFFF_FF01);
    load_fmt("lhu_off3", 5'd11, 3'b101, 2'd3, 32'h80FF_FF01, 32'h0000_80FF);
    load_fmt("lb_off0",  5'd12, 3'b000, 2'd0, 32'h80FF_FF01, 32'h0000_0001);
    load_fmt("lb_off1",  5'd13, 3'b000, 2'd1, 32'h1234_A5C3, 32'hFFFF_FFA5);
    load_fmt("lw",       5'd14, 3'b010, 2'd0, 32'h80FF_FF01, 32'h80FF_FF01);
    load_fmt("f3_011",   5'd15, 3'b011, 2'd1, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

    // ---------------- load vs execute priority ----------------
    @(negedge clk);
    u_if.ld_valid  = 1'b1;
    u_if.ld_rd     = 5'd9;
    u_if.ld_funct3 = 3'b010;
    u_if.ld_off    = 2'd0;
    @(negedge clk);
    u_if.ld_valid  = 1'b0;
    respond(32'hCAFE_F00D);
    u_if.ex_valid  = 1'b1;
    u_if.ex_rd     = 5'd10;
    u_if.ex_result = 32'h1111_2222;
    #1 check("prio_ex_ready_low", u_if.ex_ready, 32'd0);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("prio_load_waddr", u_if.rf_waddr, 32'd9);
    check("prio_load_wdata", u_if.rf_wdata, 32'hCAFE_F00D);
    #1 check("prio_ex_ready_high", u_if.ex_ready, 32'd1);
    @(negedge clk);
    u_if.ex_valid = 1'b0;
    check("prio_ex_we",    u_if.rf_we,    32'd1);
    check("prio_ex_waddr", u_if.rf_waddr, 32'd10);
    check("prio_ex_wdata", u_if.rf_wdata, 32'h1111_2222);

    // ---------------- full queue, in-order responses ----------------
    u_if.ld_valid  = 1'b1;
    u_if.ld_rd     = 5'd3;
    u_if.ld_funct3 = 3'b010;
    @(negedge clk);
    u_if.ld_rd = 5'd4;
    @(negedge clk);
    check("full_busy", u_if.busy, 32'h0000_0018);
    u_if.ld_rd = 5'd5;
    #1 check("full_ld_ready", u_if.ld_ready, 32'd0);
    @(negedge clk);
    check("full_held_busy", u_if.busy, 32'h0000_0018);
    respond(32'h3333_3333);
    #1 check("full_pop_ld_ready", u_if.ld_ready, 32'd0);
    @(negedge clk);
    check("full_x3_waddr", u_if.rf_waddr, 32'd3);
    check("full_x3_wdata", u_if.rf_wdata, 32'h3333_3333);
    check("full_x3_busy",  u_if.busy,     32'h0000_0010);
    respond(32'h4444_4444);
    #1 check("full_push_pop_ld_ready", u_if.ld_ready, 32'd1);
    @(negedge clk);
    u_if.ld_valid = 1'b0;
    check("full_x4_waddr", u_if.rf_waddr, 32'd4);
    check("full_x4_wdata", u_if.rf_wdata, 32'h4444_4444);
    check("full_x4_busy",  u_if.busy,     32'h0000_0020);
    respond(32'h5555_5555);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("full_x5_waddr", u_if.rf_waddr, 32'd5);
    check("full_x5_wdata", u_if.rf_wdata, 32'h5555_5555);
    check("full_x5_busy",  u_if.busy,     32'd0);

    // ---------------- reissue to busy register ----------------
    u_if.ld_valid = 1'b1;
    u_if.ld_rd    = 5'd3;
    @(negedge clk);
    #1 check("busy_rd_ld_ready_0", u_if.ld_ready, 32'd0);
    @(negedge clk);
    check("busy_rd_ld_ready_1", u_if.ld_ready, 32'd0);
    respond(32'h0000_0033);
    #1 check("busy_rd_ld_ready_2", u_if.ld_ready, 32'd0);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("busy_rd_we",    u_if.rf_we,    32'd1);
    check("busy_rd_busy",  u_if.busy,     32'd0);
    #1 check("busy_rd_ld_ready_3", u_if.ld_ready, 32'd1);
    @(negedge clk);
    u_if.ld_valid = 1'b0;
    check("busy_rd_reissued", u_if.busy, 32'h0000_0008);
    respond(32'h0000_0044);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("busy_rd_final", u_if.busy, 32'd0);

    // ---------------- load to x0 ----------------
    u_if.ld_valid = 1'b1;
    u_if.ld_rd    = 5'd0;
    @(negedge clk);
    u_if.ld_valid = 1'b0;
    check("x0_busy", u_if.busy, 32'd0);
    respond(32'h7777_7777);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("x0_we",  u_if.rf_we, 32'd0);
    check("x0_err", u_if.err,   32'd0);

    // ---------------- response with empty queue ----------------
    respond(32'h9999_9999);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("empty_we",  u_if.rf_we, 32'd0);
    check("empty_err", u_if.err,   32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", u_if.err, 32'd1);

    // ---------------- reset mid-queue with a pending write ----------------
    u_if.ld_valid = 1'b1;
    u_if.ld_rd    = 5'd6;
    @(negedge clk);
    u_if.ld_rd    = 5'd12;
    @(negedge clk);
    u_if.ld_valid  = 1'b0;
    u_if.ex_valid  = 1'b1;
    u_if.ex_rd     = 5'd8;
    u_if.ex_result = 32'hABCD_0123;
    check("pre_rst_busy", u_if.busy, 32'h0000_1040);
    @(posedge clk);
    #1 check("pre_rst_we", u_if.rf_we, 32'd1);
    u_if.ex_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we",       u_if.rf_we,    32'd0);
    check("mid_rst_wdata",    u_if.rf_wdata, 32'd0);
    check("mid_rst_busy",     u_if.busy,     32'd0);
    check("mid_rst_err",      u_if.err,      32'd0);
    check("mid_rst_ld_ready", u_if.ld_ready, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    // Queue was flushed, so a late response finds it empty.
    respond(32'h1234_1234);
    @(negedge clk);
    u_if.mem_rvalid = 1'b0;
    check("post_rst_we",  u_if.rf_we, 32'd0);
    check("post_rst_err", u_if.err,   32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback stage of the RISC-V core, directly upstream of the register file write port. It merges single-cycle execute results with in-order load responses from data memory and formats load data (byte/half/word, signed/unsigned). It drives one registered write per cycle into the register file and keeps a per-register busy scoreboard so decode can stall on pending load destinations.

## Interface
Parameters:
- LQ_DEPTH, 2, outstanding-load queue depth (power of two, ≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- ex_valid  in  1  execute result offered
- ex_ready  out  1  execute result accepted this cycle (valid&ready)
- ex_rd  in  5  destination register
- ex_result  in  32  value to write
- ld_valid  in  1  load being issued to memory
- ld_ready  out  1  load issue accepted (valid&ready)
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- ld_off  in  2  address bits [1:0]
- mem_rvalid  in  1  load response present (single-cycle pulse, no backpressure)
- mem_rdata  in  32  aligned response word, little-endian
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- busy  out  32  scoreboard; bit i = load to xi pending
- err  out  1  sticky: response received with empty queue

## Operation
- Load queue: FIFO of {rd, funct3, off}, LQ_DEPTH entries, in-order; push on ld_valid&ld_ready, pop on mem_rvalid with queue non-empty.
- ld_ready = !full & !busy[ld_rd]; ld_rd==0 is accepted (entry queued, no busy bit set, result discarded on write).
- ex_ready = !mem_rvalid; load response has priority for the single write port.
- Load formatting from head entry: LB/LBU select byte mem_rdata[8*off+:8], sign/zero-extend; LH/LHU select half by off[1], off[0] ignored; LW and any other funct3 pass full word.
- Write source per cycle: load response if mem_rvalid & non-empty, else execute if ex_valid, else none.
- rd==0 from either source: rf_we stays 0.
- busy[rd] set on load push (rd≠0); cleared on pop of that entry. Same-cycle set of one rd and clear of another both take effect; same-rd set+clear cannot occur (ld_ready blocks issue while busy).
- ex_valid with ex_rd busy is a protocol violation (decode must stall); bench asserts it never occurs. No correction in RTL.
- mem_rvalid with empty queue: no write, no pop, err set until reset.
- Counters use pointers with wrap at LQ_DEPTH and a count of width clog2(LQ_DEPTH)+1.

## Timing
- Reset (async assert): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, err=0, queue empty; ld_ready=1 after reset, ex_ready follows mem_rvalid combinationally.
- rf_we/rf_waddr/rf_wdata registered: source selected in cycle N appears in cycle N+1, register file commits at end of N+1; read-after-write visible from N+2.
- busy set visible cycle after push; busy clear visible in cycle N+1 together with rf_we for the response.
- Push and pop in same cycle: count unchanged; allowed when full (pop frees slot only next cycle; ld_ready uses current full).
- Reset mid-operation discards queued loads and pending write; in-flight memory responses after reset raise err.

## Test plan
- Reset then ex_valid, ex_rd=5, ex_result=0x1234_5678 at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x12345678 in N+1; ex_rd=0 -> rf_we=0.
- Issue LB rd=7 off=3, response 0x80FF_FF01 -> busy[7]=1 until write, rf_wdata=0xFFFFFF80; LBU same -> 0x00000080; LHU off=2 -> 0x000080FF; LH off=0 -> 0xFFFFFF01.
- ex_valid and mem_rvalid in same cycle -> ex_ready=0, load written first, ex result written next cycle after held.
- Issue two loads (rd=3, rd=4) with LQ_DEPTH=2 -> ld_ready=0; third issue held; responses write x3 then x4 in order, busy bits clear individually.
- Issue to rd=3 while busy[3] -> ld_ready=0 until response written.
- mem_rvalid with empty queue -> no write, err=1 sticky until rst; assert rst mid-queue -> busy=0, count=0 immediately.
